// File: rtl/adder_pkg.sv
// Shared types and helpers for the ripple-adder family.
// The serial digit adder's optional overflow output is enabled by SERIAL_ADDER_OVF_EN.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sadd_state_t;

  // The counter has to hold the values 0..NDIG.
  function automatic int cnt_width(input int ndig);
    return $clog2(ndig + 1);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational D-bit ripple adder slice used once per cycle by the serial adder.
// c_msb is the carry into the top bit, which lets the caller derive signed overflow.
module digit_adder #(
  parameter int D = 2
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         cin,
  output logic [D-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  // Ripple the carry from bit 0 upward, noting the carry entering the top bit.
  always_comb begin
    logic c;
    s     = '0;
    c_msb = 1'b0;
    c     = cin;
    for (int i = 0; i < D; i++) begin
      if (i == D - 1) c_msb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle N-bit adder that adds D bits per clock through one digit_adder slice.
// Operands arrive and results leave over valid/ready handshakes.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output.
module serial_digit_adder
  import adder_pkg::*;
#(
  parameter int N = 6,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         carry_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         carry_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         overflow
`endif
);

  localparam int NDIG = N / D;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if ((N % D) != 0 || D < 1 || D > N) begin : g_bad_params
    $error("serial_digit_adder: N must be a positive multiple of D with 1 <= D <= N");
  end

  sadd_state_t   state;
  sadd_state_t   next_state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic [N-1:0]  acc;
  logic [N-1:0]  acc_next;
  logic          carry_q;
  logic [D-1:0]  dsum;
  logic          dcout;
  logic          dcmsb;
  logic          last_digit;

  digit_adder #(
    .D(D)
  ) u_digit (
    .a    (op_a[D-1:0]),
    .b    (op_b[D-1:0]),
    .cin  (carry_q),
    .s    (dsum),
    .cout (dcout),
    .c_msb(dcmsb)
  );

  // New digit enters at the top, so after NDIG shifts digit 0 sits at bits D-1:0.
  assign acc_next   = N'({dsum, acc} >> D);
  assign last_digit = (cnt == LAST);

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
  assign overflow = ovf_q;
`else
  logic unused_c_msb;
  assign unused_c_msb = dcmsb;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and handshake outputs; in_ready is suppressed while reset is held.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        if (last_digit) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: load operands, step one digit per cycle, publish the result on the last digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      carry_q   <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a    <= A;
            op_b    <= B;
            carry_q <= carry_in;
            cnt     <= '0;
          end
        end
        RUN: begin
          op_a    <= op_a >> D;
          op_b    <= op_b >> D;
          acc     <= acc_next;
          carry_q <= dcout;
          cnt     <= cnt + CW'(1);
          if (last_digit) begin
            sum       <= acc_next;
            carry_out <= dcout;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q     <= dcmsb ^ dcout;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
